// File: rtl/division_unit_pkg.sv
// Purpose: shared encodings and sizing for the iterative RISC-V M-extension divider.
// Latency: n/a (definitions only).
// Backpressure: n/a (definitions only).
package division_unit_pkg;

    // Default operand/result width; one restoring step per bit.
    localparam int DIV_DATA_WIDTH = 32;

    // Iteration counter width: must reach DATA_WIDTH-1 with headroom.
    localparam int DIV_CNT_W = $clog2(DIV_DATA_WIDTH) + 1;

    // Operation encodings as delivered by the decoder.
    typedef enum logic [1:0] {
        OP_DIV  = 2'b00,
        OP_DIVU = 2'b01,
        OP_REM  = 2'b10,
        OP_REMU = 2'b11
    } div_op_e;

    // Controller states, kept as plain constants for legacy netlists.
    typedef logic [1:0] div_state_t;
    localparam div_state_t ST_IDLE = 2'd0;
    localparam div_state_t ST_ITER = 2'd1;
    localparam div_state_t ST_FIX  = 2'd2;
    localparam div_state_t ST_DONE = 2'd3;

    // Signed ops have OP[0] clear (DIV, REM).
    function automatic logic op_is_signed(input logic [1:0] op);
        return ~op[0];
    endfunction

    // Remainder ops have OP[1] set (REM, REMU).
    function automatic logic op_is_rem(input logic [1:0] op);
        return op[1];
    endfunction

endpackage

// File: rtl/division_unit_step.sv
// Purpose: one restoring-division step on magnitudes: shift {rem, quo} left, trial-subtract divisor.
// Latency: purely combinational.
// Backpressure: none; the caller decides when to register the result.
module division_step
    import division_unit_pkg::*;
#(
    parameter int DATA_WIDTH = DIV_DATA_WIDTH
) (
    input  logic [DATA_WIDTH:0]   rem_in,
    input  logic [DATA_WIDTH-1:0] quo_in,
    input  logic [DATA_WIDTH-1:0] divisor,
    output logic [DATA_WIDTH:0]   rem_out,
    output logic [DATA_WIDTH-1:0] quo_out
);

    logic [DATA_WIDTH+1:0] shifted;
    logic [DATA_WIDTH+1:0] diff;
    logic                  fits;

    // Shift in the next dividend bit, subtract, and keep the difference only when it is non-negative.
    always_comb begin
        shifted = {rem_in, quo_in[DATA_WIDTH-1]};
        diff    = shifted - {2'b00, divisor};
        fits    = ~diff[DATA_WIDTH+1];
        rem_out = fits ? diff[DATA_WIDTH:0] : shifted[DATA_WIDTH:0];
        quo_out = {quo_in[DATA_WIDTH-2:0], fits};
    end

endmodule

// File: rtl/division_unit.sv
// Purpose: iterative DIV/DIVU/REM/REMU for the execute stage; stalls the front end while busy.
// Latency: DATA_WIDTH+2 cycles START to RESULT_VALID (1 for div-by-zero/overflow with DIVISION_UNIT_FAST_PATH_EN).
// Backpressure: STALL_REQ held from the accepting cycle through FIX; FLUSH aborts to IDLE at the next edge.
module division_unit
    import division_unit_pkg::*;
#(
    parameter int DATA_WIDTH = DIV_DATA_WIDTH
) (
    input  logic                  CLK,
    input  logic                  RST_N,
    input  logic                  START,
    input  logic [1:0]            OP,
    input  logic [DATA_WIDTH-1:0] DIVIDEND,
    input  logic [DATA_WIDTH-1:0] DIVISOR,
    input  logic                  FLUSH,
    output logic                  STALL_REQ,
    output logic                  RESULT_VALID,
    output logic [DATA_WIDTH-1:0] RESULT
);

    localparam int                    CNT_W    = $clog2(DATA_WIDTH) + 1;
    localparam logic [CNT_W-1:0]      LAST_CNT = CNT_W'(DATA_WIDTH - 1);
    localparam logic [DATA_WIDTH-1:0] MOST_NEG = {1'b1, {(DATA_WIDTH-1){1'b0}}};
    localparam logic [DATA_WIDTH-1:0] ALL_ONES = {DATA_WIDTH{1'b1}};

    // RISC-V mandated results for the two corner cases; remainder of x/0 is x itself.
    function automatic logic [DATA_WIDTH-1:0] special_result(
        input logic                  is_rem,
        input logic                  by_zero,
        input logic [DATA_WIDTH-1:0] dvd
    );
        if (by_zero) begin
            return is_rem ? dvd : ALL_ONES;
        end
        return is_rem ? {DATA_WIDTH{1'b0}} : MOST_NEG;
    endfunction

    div_state_t            state;
    logic [CNT_W-1:0]      cnt;
    logic [DATA_WIDTH:0]   rem;
    logic [DATA_WIDTH-1:0] quo;
    logic [DATA_WIDTH-1:0] dvs;
    logic [DATA_WIDTH-1:0] dvd_raw;
    logic [DATA_WIDTH-1:0] result_q;
    logic [1:0]            op_q;
    logic                  neg_quo;
    logic                  neg_rem;
    logic                  zero_q;
    logic                  ovf_q;

    logic                  in_signed;
    logic                  a_neg;
    logic                  b_neg;
    logic [DATA_WIDTH-1:0] a_abs;
    logic [DATA_WIDTH-1:0] b_abs;
    logic                  in_zero;
    logic                  in_ovf;

    logic [DATA_WIDTH:0]   rem_nxt;
    logic [DATA_WIDTH-1:0] quo_nxt;
    logic [DATA_WIDTH-1:0] quo_fix;
    logic [DATA_WIDTH-1:0] rem_fix;
    logic [DATA_WIDTH-1:0] fix_res;

    // Operand decode: magnitudes for the unsigned core; abs(most-negative) wraps to 2^(W-1) as intended.
    always_comb begin
        in_signed = op_is_signed(OP);
        a_neg     = in_signed & DIVIDEND[DATA_WIDTH-1];
        b_neg     = in_signed & DIVISOR[DATA_WIDTH-1];
        a_abs     = a_neg ? -DIVIDEND : DIVIDEND;
        b_abs     = b_neg ? -DIVISOR  : DIVISOR;
        in_zero   = (DIVISOR == '0);
        in_ovf    = in_signed & (DIVIDEND == MOST_NEG) & (DIVISOR == ALL_ONES);
    end

    division_step #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_step (
        .rem_in  (rem),
        .quo_in  (quo),
        .divisor (dvs),
        .rem_out (rem_nxt),
        .quo_out (quo_nxt)
    );

    // Sign correction of the magnitude result, with the corner cases overriding it.
    always_comb begin
        quo_fix = neg_quo ? -quo : quo;
        rem_fix = neg_rem ? -rem[DATA_WIDTH-1:0] : rem[DATA_WIDTH-1:0];
        if (zero_q || ovf_q) begin
            fix_res = special_result(op_is_rem(op_q), zero_q, dvd_raw);
        end else begin
            fix_res = op_is_rem(op_q) ? rem_fix : quo_fix;
        end
    end

    // Controller and datapath registers; FLUSH abandons work but leaves RESULT alone.
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            state    <= ST_IDLE;
            cnt      <= '0;
            rem      <= '0;
            quo      <= '0;
            dvs      <= '0;
            dvd_raw  <= '0;
            op_q     <= '0;
            neg_quo  <= 1'b0;
            neg_rem  <= 1'b0;
            zero_q   <= 1'b0;
            ovf_q    <= 1'b0;
            result_q <= '0;
        end else if (FLUSH) begin
            state <= ST_IDLE;
            cnt   <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (START) begin
                        op_q    <= OP;
                        neg_quo <= a_neg ^ b_neg;
                        neg_rem <= a_neg;
                        zero_q  <= in_zero;
                        ovf_q   <= in_ovf;
                        dvd_raw <= DIVIDEND;
                        dvs     <= b_abs;
                        quo     <= a_abs;
                        rem     <= '0;
                        cnt     <= '0;
`ifdef DIVISION_UNIT_FAST_PATH_EN
                        if (in_zero || in_ovf) begin
                            result_q <= special_result(op_is_rem(OP), in_zero, DIVIDEND);
                            state    <= ST_DONE;
                        end else begin
                            state <= ST_ITER;
                        end
`else
                        state <= ST_ITER;
`endif
                    end
                end
                ST_ITER: begin
                    rem <= rem_nxt;
                    quo <= quo_nxt;
                    cnt <= cnt + 1'b1;
                    if (cnt == LAST_CNT) begin
                        state <= ST_FIX;
                    end
                end
                ST_FIX: begin
                    result_q <= fix_res;
                    state    <= ST_DONE;
                end
                ST_DONE: begin
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    // Stall is raised combinationally on acceptance and released in DONE so the instruction can retire.
    always_comb begin
        STALL_REQ    = ((state == ST_IDLE) & START & ~FLUSH & RST_N)
                     | (state == ST_ITER)
                     | (state == ST_FIX);
        RESULT_VALID = (state == ST_DONE);
        RESULT       = result_q;
    end

endmodule

// File: tb/tb_division_unit.sv
module tb_division_unit;
    import division_unit_pkg::*;

    localparam int W = 32;
    localparam int NORMAL_LAT = W + 2;
`ifdef DIVISION_UNIT_FAST_PATH_EN
    localparam int SPECIAL_LAT = 1;
`else
    localparam int SPECIAL_LAT = W + 2;
`endif

    logic         CLK = 1'b0;
    logic         RST_N = 1'b0;
    logic         START = 1'b0;
    logic         FLUSH = 1'b0;
    logic [1:0]   OP = 2'b00;
    logic [W-1:0] DIVIDEND = '0;
    logic [W-1:0] DIVISOR = '0;
    logic         STALL_REQ;
    logic         RESULT_VALID;
    logic [W-1:0] RESULT;

    int vecs = 0;
    int errs = 0;
    logic [W-1:0] last_res;

    division_unit #(.DATA_WIDTH(W)) dut (
        .CLK          (CLK),
        .RST_N        (RST_N),
        .START        (START),
        .OP           (OP),
        .DIVIDEND     (DIVIDEND),
        .DIVISOR      (DIVISOR),
        .FLUSH        (FLUSH),
        .STALL_REQ    (STALL_REQ),
        .RESULT_VALID (RESULT_VALID),
        .RESULT       (RESULT)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        vecs++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One operation from the first free IDLE cycle; optional stray START at cycle poke_cyc.
    task automatic run_op(input string tag, input logic [1:0] op, input logic [W-1:0] a,
                          input logic [W-1:0] b, input logic [W-1:0] exp_res,
                          input int exp_lat, input int poke_cyc);
        int cyc;
        bit stall_gap;
        @(negedge CLK);
        #1;
        check({tag, " idle_valid"}, W'(RESULT_VALID), '0);
        OP = op;
        DIVIDEND = a;
        DIVISOR = b;
        START = 1'b1;
        #1;
        check({tag, " stall_c0"}, W'(STALL_REQ), 1);
        cyc = 0;
        stall_gap = 1'b0;
        while (cyc < 100) begin
            @(negedge CLK);
            START = 1'b0;
            cyc++;
            if (cyc == poke_cyc) begin
                START = 1'b1;
                OP = OP_REMU;
                DIVIDEND = 32'h0000_1234;
                DIVISOR = 32'h0000_0005;
            end
            #1;
            if (RESULT_VALID === 1'b1) break;
            if (STALL_REQ !== 1'b1) stall_gap = 1'b1;
        end
        START = 1'b0;
        check({tag, " latency"}, W'(cyc), W'(exp_lat));
        check({tag, " result"}, RESULT, exp_res);
        check({tag, " stall_in_valid"}, W'(STALL_REQ), '0);
        check({tag, " stall_gap"}, W'(stall_gap), '0);
        last_res = exp_res;
    endtask

    initial begin
        int seen_valid;
        last_res = '0;

        // Reset
        RST_N = 1'b0;
        repeat (3) @(negedge CLK);
        RST_N = 1'b1;
        #1;
        check("reset stall", W'(STALL_REQ), '0);
        check("reset valid", W'(RESULT_VALID), '0);
        check("reset result", RESULT, '0);

        // Basic unsigned and signed
        run_op("divu_100_7", OP_DIVU, 32'd100, 32'd7, 32'd14, NORMAL_LAT, 0);
        run_op("remu_100_7", OP_REMU, 32'd100, 32'd7, 32'd2, NORMAL_LAT, 0);
        run_op("div_m7_2", OP_DIV, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, NORMAL_LAT, 0);
        run_op("rem_m7_2", OP_REM, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, NORMAL_LAT, 0);
        run_op("rem_7_m2", OP_REM, 32'd7, 32'hFFFF_FFFE, 32'd1, NORMAL_LAT, 0);

        // Special cases
        run_op("divu_5_0", OP_DIVU, 32'd5, 32'd0, 32'hFFFF_FFFF, SPECIAL_LAT, 0);
        run_op("rem_5_0", OP_REM, 32'd5, 32'd0, 32'd5, SPECIAL_LAT, 0);
        run_op("div_ovf", OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, SPECIAL_LAT, 0);
        run_op("rem_ovf", OP_REM, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, SPECIAL_LAT, 0);
        run_op("div_m5_0", OP_DIV, 32'hFFFF_FFFB, 32'd0, 32'hFFFF_FFFF, SPECIAL_LAT, 0);
        run_op("rem_m5_0", OP_REM, 32'hFFFF_FFFB, 32'd0, 32'hFFFF_FFFB, SPECIAL_LAT, 0);

        // Flush on the 10th ITER cycle
        @(negedge CLK);
        OP = OP_DIV;
        DIVIDEND = 32'd1000;
        DIVISOR = 32'd3;
        START = 1'b1;
        repeat (10) begin
            @(negedge CLK);
            START = 1'b0;
        end
        #1;
        check("flush stall_before", W'(STALL_REQ), 1);
        FLUSH = 1'b1;
        @(negedge CLK);
        FLUSH = 1'b0;
        #1;
        check("flush stall_after", W'(STALL_REQ), '0);
        check("flush valid_after", W'(RESULT_VALID), '0);
        check("flush result_kept", RESULT, last_res);
        seen_valid = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge CLK);
            #1;
            if (RESULT_VALID === 1'b1) seen_valid = 1;
        end
        check("flush no_valid", W'(seen_valid), '0);

        // FLUSH and START together
        @(negedge CLK);
        OP = OP_DIVU;
        DIVIDEND = 32'd9;
        DIVISOR = 32'd3;
        START = 1'b1;
        FLUSH = 1'b1;
        #1;
        check("flush_start stall", W'(STALL_REQ), '0);
        @(negedge CLK);
        START = 1'b0;
        FLUSH = 1'b0;
        #1;
        check("flush_start not_taken", W'(STALL_REQ), '0);
        check("flush_start no_valid", W'(RESULT_VALID), '0);
        run_op("divu_9_3", OP_DIVU, 32'd9, 32'd3, 32'd3, NORMAL_LAT, 0);

        // Back-to-back, with a stray START during the first
        run_op("divu_ff_1", OP_DIVU, 32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFF, NORMAL_LAT, 5);
        run_op("remu_ff_10", OP_REMU, 32'hFFFF_FFFF, 32'h10, 32'hF, NORMAL_LAT, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule

// File: doc/division_unit.md
# division_unit

Iterative RISC-V M-extension divider (DIV, DIVU, REM, REMU) in the execute stage. It is the requesting side of the stall protocol served by the hazard control unit. While a division is in flight it holds STALL_REQ high so the hazard control unit freezes the front of the pipeline. It drops STALL_REQ in the cycle it presents RESULT. A flush from the hazard control unit aborts the division cleanly.

## Interface
- DATA_WIDTH, 32: operand/result width; iteration count equals DATA_WIDTH.
- CLK  in  1  rising-edge clock.
- RST_N  in  1  synchronous, active-low reset.
- START  in  1  request a division; sampled only in IDLE.
- OP  in  2  00 DIV, 01 DIVU, 10 REM, 11 REMU.
- DIVIDEND  in  DATA_WIDTH  rs1 value, captured on the accepting edge.
- DIVISOR  in  DATA_WIDTH  rs2 value, captured on the accepting edge.
- FLUSH  in  1  from the hazard control unit; abort the current operation.
- STALL_REQ  out  1  to the hazard control unit; pipeline must hold.
- RESULT_VALID  out  1  one-cycle pulse; RESULT is valid.
- RESULT  out  DATA_WIDTH  quotient or remainder, selected by the latched OP.

## Operation
- States: IDLE, ITER, FIX, DONE.
- IDLE:
  - With START=1 and FLUSH=0, latch OP, the sign flags and the absolute operand values. Unsigned ops take operands as-is.
  - Clear the 6-bit iteration counter and the remainder register, then go to ITER.
- ITER: one restoring step per cycle.
  - Shift {rem, quo} left by 1 and trial-subtract the divisor.
  - Keep the difference if it is non-negative and set the quotient LSB.
  - After DATA_WIDTH steps (counter == DATA_WIDTH-1) go to FIX.
- FIX: for signed ops, negate the quotient if the operand signs differ, and negate the remainder if the dividend was negative. Then go to DONE.
- DONE: RESULT_VALID=1 for one cycle, then return to IDLE. RESULT holds its value until the next DONE.
- STALL_REQ = (IDLE & START & ~FLUSH) | ITER | FIX. It is combinational, so a stall is raised in the same cycle as START. It is low in DONE, which lets the instruction retire with RESULT.
- Special cases follow the RISC-V spec bit-exactly:
  - Divide by zero: quotient = all ones; remainder = dividend.
  - Signed overflow (most-negative / -1): quotient = most-negative; remainder = 0.
- Width rules:
  - The remainder register is DATA_WIDTH+1 bits to hold the trial-subtract sign.
  - Negation is two's complement modulo 2^DATA_WIDTH.
  - abs(most-negative) is treated as the unsigned value 2^(DATA_WIDTH-1).

## Timing
- Reset values: state IDLE; STALL_REQ=0, RESULT_VALID=0, RESULT=0; counter 0.
- START accepted at edge t: ITER runs over edges t+1..t+DATA_WIDTH, FIX is at edge t+DATA_WIDTH+1, and RESULT_VALID is high in the cycle after edge t+DATA_WIDTH+1. Latency is DATA_WIDTH+2 cycles (34 at the default width).
- START outside IDLE (including in DONE) is ignored; the pipeline is stalled, so this is legal only as a don't-care.
- Back-to-back: a new START can be accepted in the first IDLE cycle after DONE.
- FLUSH in any state: state becomes IDLE at the next edge with no RESULT_VALID. STALL_REQ is low in the cycle after that edge. RESULT keeps its last value.
- FLUSH and START in the same cycle: FLUSH wins and START is not accepted.
- FLUSH during DONE: RESULT_VALID is still high in that cycle. The hazard control unit discards it.
- RST_N low has the same effect as FLUSH and also clears RESULT.

## Configuration
- DIVISION_UNIT_FAST_PATH_EN defined: divide-by-zero and signed overflow are detected in IDLE.
  - They go directly to DONE with the special result.
  - RESULT_VALID comes one cycle after acceptance, and STALL_REQ is high only in the accepting cycle.
- Undefined: special cases take the full DATA_WIDTH+2 latency. The FIX state substitutes the spec result. Results are identical either way; only timing differs.

## Structure
- A shared package holds:
  - the OP encodings (DIV, DIVU, REM, REMU);
  - the state enum;
  - the default DATA_WIDTH;
  - the counter width, derived as clog2(DATA_WIDTH)+1.
- One combinational sub-module, division_step: inputs are {rem, quo} and the divisor; outputs are the next {rem, quo}.

## Test plan
- DIVU 100/7, then REMU 100/7: RESULT 14 and 2 respectively. RESULT_VALID exactly 34 cycles after START. STALL_REQ high for cycles 0..33 and low in the valid cycle.
- DIV -7/2 -> 0xFFFFFFFD (-3); REM -7/2 -> 0xFFFFFFFF (-1); REM 7/-2 -> 1.
- DIVU 5/0 -> 0xFFFFFFFF; REM 5/0 -> 5; DIV 0x80000000/0xFFFFFFFF -> 0x80000000; REM of the same operands -> 0. Latency is 34 cycles without the macro and 1 cycle with it.
- START DIV 1000/3, then FLUSH on the 10th ITER cycle: no RESULT_VALID, STALL_REQ low the next cycle, and RESULT unchanged from the previous value.
- FLUSH and START together: not accepted. A repeat START next cycle is accepted and DIVU 9/3 -> 3.
- Back-to-back DIVU 0xFFFFFFFF/1 then REMU 0xFFFFFFFF/0x10: RESULT 0xFFFFFFFF then 0xF. START asserted during the first operation is ignored.
